// File: rtl/lfsr_rng_gen.sv
// lfsr_rng_gen -- LFSR-based random number generator with ranged output.
//
// A Fibonacci LFSR free-runs every clock. A request latches an inclusive
// upper bound M; the generator then draws masked samples from the LFSR low
// bits, accepting the first sample <= M. After MAX_TRY consecutive rejects
// the last sample is folded back into range (s - (M+1)) so latency stays
// bounded. The result is held until the consumer accepts it.
//
// Parameters:
//   WIDTH   - LFSR width: 8, 16, 24 or 32
//   OUT_W   - output width, 1..8, OUT_W <= WIDTH
//   SEED    - non-zero reset seed (truncated to WIDTH)
//   MAX_TRY - rejection attempts before fallback, 1..15
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   seed_load  - load seed_in into the LFSR (aborts a pending draw)
//   seed_in    - seed value; zero selects SEED instead
//   req        - request one ranged value (accepted when req_ready)
//   req_ready  - high while idle
//   range_max  - inclusive upper bound, sampled on an accepted req
//   out_valid  - rand_out holds a result
//   out_ready  - consumer accepts the result
//   rand_out   - ranged result in [0, range_max]
//   rand_raw   - LFSR low OUT_W bits, combinational
//
// Build option:
//   LFSR_RNG_SEED_LOAD_EN - when defined, seed_load/seed_in are honoured;
//   otherwise they are ignored and the LFSR reseeds only through rst_n.

module lfsr_rng_gen #(
  parameter int          WIDTH   = 16,
  parameter int          OUT_W   = 8,
  parameter logic [31:0] SEED    = 32'h0000_ACE1,
  parameter int          MAX_TRY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             req_ready,
  input  logic [OUT_W-1:0] range_max,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] rand_out,
  output logic [OUT_W-1:0] rand_raw
);

  localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];
  localparam logic [3:0]       TRY_LAST = 4'(MAX_TRY - 1);

  typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

  state_t           fsm, fsm_nxt;
  logic [WIDTH-1:0] lfsr, lfsr_nxt, load_val;
  logic             fb, load;
  logic [OUT_W-1:0] m_q, m_nxt, mask_q, mask_nxt, samp;
  logic [OUT_W-1:0] rand_q, rand_nxt;
  logic             vld_q, vld_nxt;
  logic [3:0]       try_q, try_nxt;

  // Smallest all-ones value covering m: smear the leading one downwards.
  function automatic logic [OUT_W-1:0] mask_of(input logic [OUT_W-1:0] m);
    logic [OUT_W-1:0] r;
    r = m;
    for (int i = 1; i < OUT_W; i++) r = r | (m >> i);
    return r;
  endfunction

  // Maximal-length tap sets per supported width.
  generate
    if (WIDTH == 8) begin : g_taps8
      assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    end else if (WIDTH == 24) begin : g_taps24
      assign fb = lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16];
    end else if (WIDTH == 32) begin : g_taps32
      assign fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
    end else begin : g_taps16
      assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    end
  endgenerate

`ifdef LFSR_RNG_SEED_LOAD_EN
  assign load     = seed_load;
  // A zero seed would lock the LFSR, so fall back to the reset seed.
  assign load_val = (seed_in == '0) ? SEED_W : seed_in;
`else
  logic unused_seed;
  assign load        = 1'b0;
  assign load_val    = SEED_W;
  assign unused_seed = ^{seed_load, seed_in};
`endif

  assign lfsr_nxt  = load ? load_val : {lfsr[WIDTH-2:0], fb};
  assign samp      = lfsr[OUT_W-1:0] & mask_q;
  assign rand_raw  = lfsr[OUT_W-1:0];
  assign req_ready = (fsm == IDLE);
  assign out_valid = vld_q;
  assign rand_out  = rand_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm    <= IDLE;
      lfsr   <= SEED_W;
      m_q    <= '0;
      mask_q <= '0;
      try_q  <= '0;
      rand_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      fsm    <= fsm_nxt;
      lfsr   <= lfsr_nxt;
      m_q    <= m_nxt;
      mask_q <= mask_nxt;
      try_q  <= try_nxt;
      rand_q <= rand_nxt;
      vld_q  <= vld_nxt;
    end
  end

  always_comb begin
    fsm_nxt  = fsm;
    m_nxt    = m_q;
    mask_nxt = mask_q;
    try_nxt  = try_q;
    rand_nxt = rand_q;
    vld_nxt  = vld_q;
    if (load) begin
      // Reseeding invalidates any draw in flight; rand_out keeps its value.
      fsm_nxt = IDLE;
      vld_nxt = 1'b0;
      try_nxt = '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (req) begin
            fsm_nxt  = DRAW;
            m_nxt    = range_max;
            mask_nxt = mask_of(range_max);
            try_nxt  = '0;
          end
        end
        DRAW: begin
          if (samp <= m_q) begin
            rand_nxt = samp;
            vld_nxt  = 1'b1;
            fsm_nxt  = HOLD;
          end else if (try_q == TRY_LAST) begin
            // samp is in (M, mask] and mask <= 2M+1, so this lands in [0, M].
            rand_nxt = samp - m_q - OUT_W'(1);
            vld_nxt  = 1'b1;
            fsm_nxt  = HOLD;
          end else begin
            try_nxt = try_q + 4'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            vld_nxt = 1'b0;
            fsm_nxt = IDLE;
          end
        end
        default: fsm_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng_gen.sv
module tb_lfsr_rng_gen;

  localparam int          WIDTH   = 16;
  localparam int          OUT_W   = 8;
  localparam int          MAX_TRY = 4;
  localparam logic [15:0] SEED    = 16'hACE1;

`ifdef LFSR_RNG_SEED_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;
  logic        req = 1'b0;
  logic        req_ready;
  logic [7:0]  range_max = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  rand_out;
  logic [7:0]  rand_raw;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mstate;

  lfsr_rng_gen #(
    .WIDTH(WIDTH), .OUT_W(OUT_W), .SEED(32'h0000_ACE1), .MAX_TRY(MAX_TRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .req_ready(req_ready), .range_max(range_max),
    .out_valid(out_valid), .out_ready(out_ready),
    .rand_out(rand_out), .rand_raw(rand_raw)
  );

  always #5 clk = ~clk;

  // Next LFSR value from the tap list, using plain integer arithmetic.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int v, f;
    v = int'(s);
    f = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'(((v << 1) | f) & 32'hFFFF);
  endfunction

  function automatic int mask_for(input int m);
    int k;
    k = 0;
    while (((1 << k) - 1) < m) k++;
    return (1 << k) - 1;
  endfunction

  // Reference LFSR trajectory.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mstate <= SEED;
    else if (LOAD_EN && seed_load) mstate <= (seed_in == 16'h0) ? SEED : seed_in;
    else mstate <= lfsr_step(mstate);
  end

  // Predict result and latency of a request accepted at the next edge.
  task automatic predict(input int m, output int exp_val, output int exp_lat);
    logic [15:0] st;
    int s, mk;
    st = lfsr_step(mstate);
    mk = mask_for(m);
    exp_val = -1;
    exp_lat = 0;
    for (int i = 0; i < MAX_TRY; i++) begin
      s = int'(st[7:0]) & mk;
      if (exp_val < 0 && s <= m) begin
        exp_val = s;
        exp_lat = i + 2;
      end else if (exp_val < 0 && i == MAX_TRY - 1) begin
        exp_val = s - (m + 1);
        exp_lat = i + 2;
      end
      st = lfsr_step(st);
    end
  endtask

  // Issue one request, check result/latency, hold for 'hold' cycles, then accept.
  task automatic run_req(input logic [7:0] m, input int hold, output logic [7:0] got,
                         output int lat);
    int exp_val, exp_lat, n;
    predict(int'(m), exp_val, exp_lat);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    req = 1'b1;
    range_max = m;
    @(negedge clk);
    req = 1'b0;
    range_max = 8'($urandom);
    n = 1;
    while (out_valid !== 1'b1 && n < MAX_TRY + 6) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    got = rand_out;
    vectors++;
    if (out_valid !== 1'b1 || n != exp_lat) begin
      miscompares++;
      $display("FAIL latency m=%0d: got %0d cycles (valid=%b) want %0d", m, n, out_valid, exp_lat);
    end
    vectors++;
    if (rand_out !== 8'(exp_val)) begin
      miscompares++;
      $display("FAIL rand_out m=%0d: got %0d want %0d", m, rand_out, exp_val);
    end
    for (int h = 0; h < hold; h++) begin
      req = 1'($urandom);
      range_max = 8'($urandom);
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || rand_out !== got || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_stable: valid=%b out=%0d ready=%b want 1/%0d/0",
                 out_valid, rand_out, req_ready, got);
      end
    end
    req = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL handshake_idle: valid=%b ready=%b want 0/1", out_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0 || rand_out !== 8'h00 || rand_raw !== 8'hE1) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b valid=%b out=%h raw=%h want 1/0/00/E1",
               req_ready, out_valid, rand_out, rand_raw);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (rand_raw !== 8'hC3) begin
      miscompares++;
      $display("FAIL first_step: raw=%h want C3", rand_raw);
    end
  endtask

  task automatic test_lfsr();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      vectors++;
      if (rand_raw !== mstate[7:0]) begin
        miscompares++;
        $display("FAIL lfsr_seq step %0d: raw=%h want %h", i, rand_raw, mstate[7:0]);
      end
    end
  endtask

  task automatic test_seed_load();
    logic [15:0] vals [3];
    vals[0] = 16'h0000;
    vals[1] = 16'h0001;
    vals[2] = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      seed_load = 1'b1;
      seed_in = vals[i];
      @(negedge clk);
      seed_load = 1'b0;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (rand_raw !== mstate[7:0]) begin
          miscompares++;
          $display("FAIL seed_load %h step %0d: raw=%h want %h", vals[i], k, rand_raw, mstate[7:0]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_edges();
    logic [7:0] got;
    int lat;
    run_req(8'h00, 0, got, lat);
    vectors++;
    if (got !== 8'h00 || lat != 2) begin
      miscompares++;
      $display("FAIL m0_min_latency: val=%0d lat=%0d want 0/2", got, lat);
    end
    run_req(8'hFF, 0, got, lat);
    vectors++;
    if (lat != 2) begin
      miscompares++;
      $display("FAIL mff_first_draw: lat=%0d want 2", lat);
    end
  endtask

  task automatic test_range9();
    bit seen [10];
    logic [7:0] got;
    int lat, nseen;
    for (int i = 0; i < 10; i++) seen[i] = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      run_req(8'd9, 0, got, lat);
      vectors++;
      if (got > 8'd9 || lat < 2 || lat > 1 + MAX_TRY) begin
        miscompares++;
        $display("FAIL range9_bounds: val=%0d lat=%0d", got, lat);
      end
      if (got <= 8'd9) seen[got] = 1'b1;
    end
    nseen = 0;
    for (int i = 0; i < 10; i++) nseen += int'(seen[i]);
    vectors++;
    if (nseen != 10) begin
      miscompares++;
      $display("FAIL range9_coverage: distinct=%0d want 10", nseen);
    end
  endtask

  task automatic test_random();
    logic [7:0] got, m;
    int lat;
    for (int i = 0; i < 150; i++) begin
      m = 8'($urandom);
      run_req(m, int'($urandom_range(0, 3)), got, lat);
      vectors++;
      if (got > m) begin
        miscompares++;
        $display("FAIL random_bounds: val=%0d m=%0d", got, m);
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] got;
    int lat;
    run_req(8'd37, 20, got, lat);
  endtask

  task automatic test_reset_mid();
    int exp_val, exp_lat;
    predict(200, exp_val, exp_lat);
    req = 1'b1;
    range_max = 8'd200;
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1 || rand_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid_draw: valid=%b ready=%b out=%h want 0/1/00",
               out_valid, req_ready, rand_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || req_ready !== 1'b1 || rand_raw !== mstate[7:0]) begin
        miscompares++;
        $display("FAIL reset_mid_after %0d: valid=%b ready=%b raw=%h want 0/1/%h",
                 i, out_valid, req_ready, rand_raw, mstate[7:0]);
      end
    end
  endtask

`ifdef LFSR_RNG_SEED_LOAD_EN
  task automatic test_seed_abort();
    logic [7:0] prev;
    int n;
    prev = rand_out;
    req = 1'b1;
    range_max = 8'd100;
    @(negedge clk);
    req = 1'b0;
    seed_load = 1'b1;
    seed_in = 16'($urandom);
    @(negedge clk);
    seed_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b0 || req_ready !== 1'b1 || rand_out !== prev) begin
        miscompares++;
        $display("FAIL seed_abort_draw %0d: valid=%b ready=%b out=%h want 0/1/%h",
                 i, out_valid, req_ready, rand_out, prev);
      end
      @(negedge clk);
    end
    req = 1'b1;
    range_max = 8'd50;
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < MAX_TRY + 4) begin
      @(negedge clk);
      n++;
    end
    prev = rand_out;
    seed_load = 1'b1;
    seed_in = 16'h0000;
    @(negedge clk);
    seed_load = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1 || rand_out !== prev || rand_raw !== mstate[7:0]) begin
      miscompares++;
      $display("FAIL seed_abort_hold: valid=%b ready=%b out=%h raw=%h want 0/1/%h/%h",
               out_valid, req_ready, rand_out, rand_raw, prev, mstate[7:0]);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lfsr();
    test_seed_load();
    test_edges();
    test_range9();
    test_random();
    test_hold();
    test_reset_mid();
`ifdef LFSR_RNG_SEED_LOAD_EN
    test_seed_abort();
`endif
    test_lfsr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lfsr_rng_gen.md
LFSR_RNG_GEN -- requirements
Module: lfsr_rng_gen

Interface
REQ-001 Parameter WIDTH, default 16: LFSR state width; legal values 8, 16, 24, 32 only.
REQ-002 Parameter OUT_W, default 8: output width, 1..8, and OUT_W <= WIDTH.
REQ-003 Parameter SEED, default 16'hACE1 (zero-extended/truncated to WIDTH): reset seed; SHALL be non-zero.
REQ-004 Parameter MAX_TRY, default 4: rejection attempts before fallback, 1..15.
REQ-005 clk  input  1  system clock, rising-edge active.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 seed_load  input  1  load seed_in into LFSR this cycle.
REQ-008 seed_in  input  WIDTH  seed value.
REQ-009 req  input  1  request one ranged random value.
REQ-010 req_ready  output  1  high exactly when FSM is IDLE.
REQ-011 range_max  input  OUT_W  inclusive upper bound of requested value, sampled on accepted req.
REQ-012 out_valid  output  1  rand_out holds a result.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 rand_out  output  OUT_W  ranged result, in [0, range_max].
REQ-015 rand_raw  output  OUT_W  LFSR state bits [OUT_W-1:0], unregistered.

Function
REQ-016 LFSR SHALL shift left each clock, {state[WIDTH-2:0], fb}, unconditionally except on seed-load cycles.
REQ-017 fb = XOR of taps: WIDTH 8 -> bits 7,5,4,3; 16 -> 15,13,12,10; 24 -> 23,22,21,16; 32 -> 31,21,1,0.
REQ-018 seed_load SHALL write seed_in, or SEED if seed_in == 0; the state SHALL never become zero.
REQ-019 FSM states IDLE, DRAW, HOLD; req accepted when req && req_ready; IDLE -> DRAW, latching range_max as M and clearing the try counter.
REQ-020 mask = smallest 2^k-1 >= M (M=0 -> mask 0); sample s = state[OUT_W-1:0] & mask, taken every DRAW cycle.
REQ-021 DRAW: s <= M -> rand_out <= s, out_valid <= 1, go HOLD; else try counter +1.
REQ-022 On the MAX_TRY-th consecutive reject, rand_out SHALL be s - (M+1), out_valid <= 1, go HOLD.
REQ-023 Latency: req accepted in cycle t -> out_valid earliest in cycle t+2, latest t+1+MAX_TRY.
REQ-024 HOLD: rand_out and out_valid stable until out_valid && out_ready; then out_valid <= 0, go IDLE; next req accepted one cycle later.
REQ-025 M = 0 SHALL always return 0 with minimum latency.
REQ-026 seed_load in DRAW or HOLD SHALL abort: go IDLE, out_valid <= 0, rand_out unchanged; seed_load has priority over all other events.
REQ-027 req while not IDLE SHALL be ignored (no queueing).

Reset
REQ-028 rst_n low SHALL immediately set LFSR = SEED, FSM = IDLE, out_valid = 0, rand_out = 0, try counter = 0; req_ready = 1 during and after reset.
REQ-029 Reset asserted mid-DRAW or mid-HOLD SHALL discard the pending result with no out_valid pulse.

Configuration
REQ-030 Macro LFSR_RNG_SEED_LOAD_EN defined: REQ-018 and REQ-026 behaviour present.
REQ-031 Macro undefined: seed_load and seed_in ports remain but are ignored; LFSR reseeds only via rst_n.

Verification
REQ-032 WIDTH=16, SEED=ACE1: release reset, one clock -> state 59C3, rand_raw C3.
REQ-033 Seed load seed_in=0 -> state ACE1 next cycle; seed_in=0001 -> state 0001, then 0002.
REQ-034 req with range_max=9, out_ready=1 over 1000 requests -> every rand_out in 0..9, all ten values seen, latency 2..1+MAX_TRY cycles.
REQ-035 range_max=0 -> rand_out 0, out_valid at t+2; range_max=FF -> accepted on first DRAW cycle.
REQ-036 out_ready held low 20 cycles in HOLD -> rand_out/out_valid stable, req ignored; out_ready high -> IDLE next cycle.
REQ-037 seed_load, then rst_n low, each mid-DRAW -> no out_valid, FSM IDLE, req_ready high next cycle.
